counter_pwm_compare: RTL and testbench
======================================

// Module: counter_pwm_compare
// PURPOSE
//  Downstream consumer of the free-running 8-bit counter's count bus. Generates a
//  registered PWM output by comparing count against a double-buffered duty value.
//  Detects counter wrap-around (MAX->0) to apply new duty values glitch-free, and
//  flags any break in the +1 count sequence. Sits between the counter and pad/driver logic.
// PARAMETERS
//  WIDTH     8     width of count and duty (count wraps at 2**WIDTH-1)
//  DUTY_RST  0     active duty value loaded on reset
//  WRAP_W    16    width of wrap event counter
// PORTS
//  clk         in   1        rising-edge clock, same clock as the counter
//  reset       in   1        synchronous, active-high reset
//  count       in   WIDTH    counter value, expected to increment by 1 every cycle
//  duty_data   in   WIDTH    new duty value
//  duty_valid  in   1        duty_data valid
//  duty_ready  out  1        shadow register empty; duty can be accepted
//  err_clr     in   1        clears sticky seq_err
//  pwm_out     out  1        registered PWM output
//  wrap_pulse  out  1        one-cycle pulse, registered, per detected wrap
//  wrap_cnt    out  WRAP_W   number of wraps since reset, modulo 2**WRAP_W
//  seq_err     out  1        sticky: count sequence broken
// BEHAVIOUR
//  Reset (sync, high): pwm_out=0, wrap_pulse=0, wrap_cnt=0, seq_err=0, active_duty=DUTY_RST,
//   shadow_full=0 (so duty_ready=1), prev_valid=0. Reset wins over every other event.
//  Internal state: prev_count (count sampled last cycle), prev_valid, active_duty,
//   shadow_duty, shadow_full.
//  prev_count<=count every cycle; prev_valid<=1 on the first non-reset cycle.
//  wrap_now (comb) = prev_valid & (prev_count==2**WIDTH-1) & (count==0).
//  Duty handshake: duty_ready = !shadow_full (comb). Transfer when duty_valid&duty_ready:
//   shadow_duty<=duty_data, shadow_full<=1. duty_data is held stable while valid & !ready.
//  Duty apply: on wrap_now with shadow_full=1: active_duty<=shadow_duty, shadow_full<=0.
//  Same-cycle transfer and wrap_now: shadow_full was 0 -> value goes to shadow only and
//   applies at the NEXT wrap. Shadow is never overwritten while full.
//  duty_eff (comb) = (wrap_now & shadow_full) ? shadow_duty : active_duty.
//  pwm_out <= (count < duty_eff), unsigned compare; latency 1 cycle from count.
//   New duty takes effect from the count==0 sample of the wrap, never mid-period.
//   duty=0 -> pwm_out constantly 0; duty=MAX -> low only for count==MAX.
//  wrap_pulse <= wrap_now; wrap_cnt <= wrap_cnt+1 (modulo 2**WRAP_W) on wrap_now.
//  seq_err: set when prev_valid & (count != prev_count+1 mod 2**WIDTH); stays set;
//   err_clr clears it; set beats clear in the same cycle. First sample after reset is
//   never checked (prev_valid=0).
//  A count that jumps (e.g. 200->0) is not a wrap: no duty apply, no wrap_pulse, seq_err=1.
// TESTING
//  1. Reset then count 0..255,0 with DUTY_RST=0 -> pwm_out 0 throughout; wrap_pulse one
//     cycle after count==0 seen; wrap_cnt=1; seq_err=0.
//  2. Send duty=64 at count=10 -> duty_ready drops next cycle; pwm_out stays 0 until the
//     wrap; then high for count 0..63 (1-cycle lag); low for 64..255; duty_ready=1 again.
//  3. Send duty=128 in the cycle where count==0 after 255 -> accepted into shadow; period
//     continues with old duty; 128 applies at the following wrap.
//  4. While shadow full, hold duty_valid=1 with duty=32 -> no transfer, ready=0; after wrap
//     transfer occurs next cycle and 32 applies one wrap later.
//  5. Force count 100->150 -> seq_err=1 one cycle later, stays set; err_clr pulse -> 0;
//     err_clr in same cycle as new jump -> seq_err remains 1.
//  6. Assert reset mid-period with shadow full and duty=200 active -> next cycle pwm_out=0,
//     duty_ready=1, wrap_cnt=0, active duty=DUTY_RST; first sample after reset is unchecked.

Source files
------------

// File: rtl/counter_pwm_compare.sv
// counter_pwm_compare
//   Consumes the count bus of a free-running counter and produces a registered PWM
//   output from an unsigned compare against a double-buffered duty value. A new duty
//   value lands in a shadow register and only becomes active on a detected MAX->0
//   wrap, so a period is never cut short or stretched. Any break in the +1 count
//   sequence raises a sticky error flag.
//
// Ports
//   clk         in   rising-edge clock, shared with the counter
//   reset       in   synchronous, active-high reset
//   count       in   counter value, expected to advance by one every cycle
//   duty_data   in   new duty value offered to the shadow register
//   duty_valid  in   duty_data is valid
//   duty_ready  out  shadow register is empty and can take duty_data
//   err_clr     in   clears the sticky seq_err flag
//   pwm_out     out  registered PWM output, one cycle behind count
//   wrap_pulse  out  registered one-cycle pulse per detected wrap
//   wrap_cnt    out  wraps seen since reset, modulo 2**WRAP_W
//   seq_err     out  sticky flag: count sequence was broken
module counter_pwm_compare #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DUTY_RST = 0,
    parameter int unsigned WRAP_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  count,
    input  logic [WIDTH-1:0]  duty_data,
    input  logic              duty_valid,
    output logic              duty_ready,
    input  logic              err_clr,
    output logic              pwm_out,
    output logic              wrap_pulse,
    output logic [WRAP_W-1:0] wrap_cnt,
    output logic              seq_err
);

    localparam logic [WIDTH-1:0] MaxCount = '1;
    localparam logic [WIDTH-1:0] DutyRst  = WIDTH'(DUTY_RST);

    logic [WIDTH-1:0]  prev_count_q, prev_count_d;
    logic              prev_valid_q, prev_valid_d;
    logic [WIDTH-1:0]  active_duty_q, active_duty_d;
    logic [WIDTH-1:0]  shadow_duty_q, shadow_duty_d;
    logic              shadow_full_q, shadow_full_d;
    logic              pwm_q, pwm_d;
    logic              wrap_pulse_q, wrap_pulse_d;
    logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;
    logic              seq_err_q, seq_err_d;

    logic              wrap_now;
    logic              apply_duty;
    logic              duty_xfer;
    logic              seq_break;
    logic [WIDTH-1:0]  expected_count;
    logic [WIDTH-1:0]  duty_eff;

    always_comb begin
        expected_count = prev_count_q + WIDTH'(1);
        // A jump straight to 0 from anything but MAX is a sequence error, not a wrap.
        wrap_now       = prev_valid_q && (prev_count_q == MaxCount) && (count == '0);
        seq_break      = prev_valid_q && (count != expected_count);
        apply_duty     = wrap_now && shadow_full_q;
        duty_ready     = !shadow_full_q;
        duty_xfer      = duty_valid && !shadow_full_q;
        // The incoming duty must already govern the count==0 sample of the wrap.
        duty_eff       = apply_duty ? shadow_duty_q : active_duty_q;
    end

    always_comb begin
        prev_count_d  = count;
        prev_valid_d  = 1'b1;
        active_duty_d = active_duty_q;
        shadow_duty_d = shadow_duty_q;
        shadow_full_d = shadow_full_q;
        pwm_d         = (count < duty_eff);
        wrap_pulse_d  = wrap_now;
        wrap_cnt_d    = wrap_cnt_q;
        seq_err_d     = seq_err_q;

        // Transfer needs an empty shadow and apply needs a full one, so they never collide.
        if (duty_xfer) begin
            shadow_duty_d = duty_data;
            shadow_full_d = 1'b1;
        end else if (apply_duty) begin
            active_duty_d = shadow_duty_q;
            shadow_full_d = 1'b0;
        end

        if (wrap_now) begin
            wrap_cnt_d = wrap_cnt_q + WRAP_W'(1);
        end

        // Set has priority over clear.
        if (seq_break) begin
            seq_err_d = 1'b1;
        end else if (err_clr) begin
            seq_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_count_q  <= '0;
            prev_valid_q  <= 1'b0;
            active_duty_q <= DutyRst;
            shadow_duty_q <= '0;
            shadow_full_q <= 1'b0;
            pwm_q         <= 1'b0;
            wrap_pulse_q  <= 1'b0;
            wrap_cnt_q    <= '0;
            seq_err_q     <= 1'b0;
        end else begin
            prev_count_q  <= prev_count_d;
            prev_valid_q  <= prev_valid_d;
            active_duty_q <= active_duty_d;
            shadow_duty_q <= shadow_duty_d;
            shadow_full_q <= shadow_full_d;
            pwm_q         <= pwm_d;
            wrap_pulse_q  <= wrap_pulse_d;
            wrap_cnt_q    <= wrap_cnt_d;
            seq_err_q     <= seq_err_d;
        end
    end

    assign pwm_out    = pwm_q;
    assign wrap_pulse = wrap_pulse_q;
    assign wrap_cnt   = wrap_cnt_q;
    assign seq_err    = seq_err_q;

endmodule

// File: tb/tb_counter_pwm_compare.sv
// Testbench for counter_pwm_compare: directed scenarios followed by randomized counting
// with occasional jumps, duty requests, error clears and resets, all checked against a
// behavioural model built from queues and integer arithmetic.
module tb_counter_pwm_compare;

    logic        clk;
    logic        reset;
    logic [7:0]  count;
    logic [7:0]  duty_data;
    logic        duty_valid;
    logic        duty_ready;
    logic        err_clr;
    logic        pwm_out;
    logic        wrap_pulse;
    logic [15:0] wrap_cnt;
    logic        seq_err;

    counter_pwm_compare #(
        .WIDTH    (8),
        .DUTY_RST (0),
        .WRAP_W   (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .count      (count),
        .duty_data  (duty_data),
        .duty_valid (duty_valid),
        .duty_ready (duty_ready),
        .err_clr    (err_clr),
        .pwm_out    (pwm_out),
        .wrap_pulse (wrap_pulse),
        .wrap_cnt   (wrap_cnt),
        .seq_err    (seq_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int         m_prev;      // previous count, -1 when none since reset
    int         m_active;    // duty currently governing the period
    int         m_pend[$];   // duty waiting for the next wrap (at most one)
    int         m_wraps;
    bit         m_pwm;
    bit         m_pulse;
    bit         m_err;
    bit         accepted;
    int         cnt;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_prev   = -1;
        m_active = 0;
        m_pend.delete();
        m_wraps  = 0;
        m_pwm    = 0;
        m_pulse  = 0;
        m_err    = 0;
    endtask

    // One clock: drive at negedge, check ready before the edge, update model, check after.
    task automatic step(input bit rst, input int c, input bit vld, input int d, input bit clr);
        bit wrap;
        bit brk;
        int eff;
        @(negedge clk);
        reset      = rst;
        count      = c[7:0];
        duty_valid = vld;
        duty_data  = d[7:0];
        err_clr    = clr;
        #1;
        check_eq("duty_ready", {31'd0, duty_ready}, {31'd0, (m_pend.size() == 0)});
        accepted = vld && (m_pend.size() == 0) && !rst;
        if (rst) begin
            model_reset();
        end else begin
            wrap  = (m_prev == 255) && (c == 0);
            brk   = (m_prev >= 0) && (c != (m_prev + 1) % 256);
            eff   = (wrap && m_pend.size() != 0) ? m_pend[0] : m_active;
            m_pwm = (c < eff);
            if (wrap && m_pend.size() != 0) m_active = m_pend.pop_front();
            else if (vld && m_pend.size() == 0) m_pend.push_back(d);
            m_pulse = wrap;
            if (wrap) m_wraps = (m_wraps + 1) % 65536;
            if (brk) m_err = 1;
            else if (clr) m_err = 0;
            m_prev = c;
        end
        @(posedge clk);
        #1;
        check_eq("pwm_out", {31'd0, pwm_out}, {31'd0, m_pwm});
        check_eq("wrap_pulse", {31'd0, wrap_pulse}, {31'd0, m_pulse});
        check_eq("wrap_cnt", {16'd0, wrap_cnt}, m_wraps);
        check_eq("seq_err", {31'd0, seq_err}, {31'd0, m_err});
    endtask

    task automatic tick(input bit vld, input int d, input bit clr);
        step(1'b0, cnt, vld, d, clr);
        cnt = (cnt + 1) % 256;
    endtask

    task automatic run_to(input int target);
        while (cnt != target) tick(1'b0, 0, 1'b0);
    endtask

    initial begin
        int pick;
        int rd;
        bit rvld;
        reset      = 1'b1;
        count      = '0;
        duty_data  = '0;
        duty_valid = 1'b0;
        err_clr    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check_eq("rst_pwm", {31'd0, pwm_out}, 32'd0);
        check_eq("rst_pulse", {31'd0, wrap_pulse}, 32'd0);
        check_eq("rst_wraps", {16'd0, wrap_cnt}, 32'd0);
        check_eq("rst_err", {31'd0, seq_err}, 32'd0);
        check_eq("rst_ready", {31'd0, duty_ready}, 32'd1);

        // 1: one full period plus the wrap with duty 0
        cnt = 0;
        repeat (257) tick(1'b0, 0, 1'b0);
        check_eq("s1_wraps", {16'd0, wrap_cnt}, 32'd1);
        check_eq("s1_err", {31'd0, seq_err}, 32'd0);

        // 2: duty 64 offered at count 10, applies at the next wrap
        run_to(10);
        tick(1'b1, 64, 1'b0);
        check_eq("s2_ready_low", {31'd0, duty_ready}, 32'd0);
        run_to(0);
        tick(1'b0, 0, 1'b0);
        check_eq("s2_pwm_at0", {31'd0, pwm_out}, 32'd1);
        run_to(63);
        tick(1'b0, 0, 1'b0);
        check_eq("s2_pwm_at63", {31'd0, pwm_out}, 32'd1);
        tick(1'b0, 0, 1'b0);
        check_eq("s2_pwm_at64", {31'd0, pwm_out}, 32'd0);
        check_eq("s2_ready_hi", {31'd0, duty_ready}, 32'd1);

        // 3: duty 128 offered on the wrap cycle goes to shadow only
        run_to(0);
        tick(1'b1, 128, 1'b0);
        run_to(100);
        tick(1'b0, 0, 1'b0);
        check_eq("s3_old_duty", {31'd0, pwm_out}, 32'd0);
        run_to(0);
        tick(1'b0, 0, 1'b0);
        run_to(100);
        tick(1'b0, 0, 1'b0);
        check_eq("s3_new_duty", {31'd0, pwm_out}, 32'd1);

        // 4: fill shadow with 200, then hold 32 valid across the wrap
        tick(1'b1, 200, 1'b0);
        while (cnt != 0) tick(1'b1, 32, 1'b0);
        tick(1'b1, 32, 1'b0);
        tick(1'b1, 32, 1'b0);
        check_eq("s4_xfer", {31'd0, duty_ready}, 32'd0);
        run_to(50);
        tick(1'b0, 0, 1'b0);
        check_eq("s4_duty200", {31'd0, pwm_out}, 32'd1);

        // 6: reset mid-period with shadow full and duty 200 active
        step(1'b1, 51, 1'b0, 0, 1'b0);
        check_eq("s6_pwm", {31'd0, pwm_out}, 32'd0);
        check_eq("s6_ready", {31'd0, duty_ready}, 32'd1);
        check_eq("s6_wraps", {16'd0, wrap_cnt}, 32'd0);
        cnt = 77;
        tick(1'b0, 0, 1'b0);
        check_eq("s6_unchecked", {31'd0, seq_err}, 32'd0);
        tick(1'b0, 0, 1'b0);
        check_eq("s6_duty_rst", {31'd0, pwm_out}, 32'd0);

        // 5: jump 100->150, clear, then clear colliding with a new jump
        run_to(101);
        cnt = 150;
        tick(1'b0, 0, 1'b0);
        check_eq("s5_set", {31'd0, seq_err}, 32'd1);
        repeat (3) tick(1'b0, 0, 1'b0);
        check_eq("s5_sticky", {31'd0, seq_err}, 32'd1);
        tick(1'b0, 0, 1'b1);
        check_eq("s5_clr", {31'd0, seq_err}, 32'd0);
        cnt = 10;
        tick(1'b0, 0, 1'b1);
        check_eq("s5_set_wins", {31'd0, seq_err}, 32'd1);
        tick(1'b0, 0, 1'b1);
        check_eq("s5_clr2", {31'd0, seq_err}, 32'd0);

        // Random phase
        rvld = 1'b0;
        rd   = 0;
        for (int i = 0; i < 4000; i++) begin
            if (!rvld && ($urandom % 40) == 0) begin
                rvld = 1'b1;
                pick = $urandom % 5;
                rd   = (pick == 0) ? 0 : (pick == 1) ? 255 : (pick == 2) ? 1 :
                       (pick == 3) ? 254 : int'($urandom % 256);
            end
            if (($urandom % 64) == 0) cnt = $urandom % 256;
            if (($urandom % 700) == 0) begin
                step(1'b1, cnt, rvld, rd, 1'b0);
            end else begin
                step(1'b0, cnt, rvld, rd, ($urandom % 20) == 0);
            end
            if (accepted) rvld = 1'b0;
            cnt = (cnt + 1) % 256;
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
